// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// Module   : data_cache
// Purpose  : N-way set-associative write-back, write-allocate L1 data cache
//            with byte-strobed stores, true-LRU replacement and full flush.
// Revision : 1.0
// ============================================================================
module data_cache #(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDR_WIDTH         = 16,
    parameter int ASSO_WIDTH         = 1,
    parameter int BLOCK_OFFSET_WIDTH = 5,
    parameter int INDEX_WIDTH        = 3,
    parameter int TAG_WIDTH          = ADDR_WIDTH - INDEX_WIDTH - BLOCK_OFFSET_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic                    enable,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    flush,
    output logic                    ready,
    output logic [DATA_WIDTH-1:0]   data,
    output logic                    data_valid,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_enable,
    output logic                    mem_write,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_read,
    input  logic                    mem_read_valid,
    input  logic                    mem_write_ready,
    input  logic                    mem_last
);
    localparam int WAYS    = 1 << ASSO_WIDTH;
    localparam int SETS    = 1 << INDEX_WIDTH;
    localparam int ENTRIES = SETS * WAYS;
    localparam int WAY_W   = (ASSO_WIDTH > 0) ? ASSO_WIDTH : 1;
    localparam int ENT_W   = INDEX_WIDTH + ASSO_WIDTH;
    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam logic [WAY_W-1:0] c_AGE_MAX = WAY_W'(WAYS - 1);
    localparam logic [ENT_W-1:0] c_LAST_ENT = ENT_W'(ENTRIES - 1);

    localparam logic [1:0] S_READY     = 2'd0;
    localparam logic [1:0] S_WRITEBACK = 2'd1;
    localparam logic [1:0] S_REFILL    = 2'd2;
    localparam logic [1:0] S_FLUSH     = 2'd3;

    logic [TAG_WIDTH-1:0]  r_tag  [ENTRIES];
    logic [WAY_W-1:0]      r_age  [ENTRIES];
    logic [DATA_WIDTH-1:0] r_line [ENTRIES << BLOCK_OFFSET_WIDTH];
    logic [ENTRIES-1:0]    r_valid;
    logic [ENTRIES-1:0]    r_dirty;

    logic [1:0]                    r_state;
    logic [BLOCK_OFFSET_WIDTH-1:0] r_cnt;
    logic [TAG_WIDTH-1:0]          r_tag_l;
    logic [INDEX_WIDTH-1:0]        r_idx_l;
    logic [WAY_W-1:0]              r_way_l;
    logic [ENT_W-1:0]              r_scan;

    logic [TAG_WIDTH-1:0]          w_tag;
    logic [INDEX_WIDTH-1:0]        w_idx;
    logic [BLOCK_OFFSET_WIDTH-1:0] w_off;
    logic                          w_hit;
    logic [WAY_W-1:0]              w_hit_way;
    logic                          w_inv;
    logic [WAY_W-1:0]              w_vic_way;
    logic [ENT_W-1:0]              w_hit_ent;
    logic [ENT_W-1:0]              w_vic_ent;
    logic [ENT_W-1:0]              w_lat_ent;
    logic                          w_served;
    logic                          w_fl_dirty;
    logic [INDEX_WIDTH-1:0]        w_fl_idx;
    logic                          w_touch;
    logic [INDEX_WIDTH-1:0]        w_touch_idx;
    logic [WAY_W-1:0]              w_touch_way;
    logic [WAY_W-1:0]              w_touch_old;

    function automatic logic [ENT_W-1:0] f_ent(input logic [INDEX_WIDTH-1:0] idx,
                                               input logic [WAY_W-1:0] way);
        return ENT_W'(int'(idx) * WAYS + int'(way));
    endfunction

    assign w_tag = addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign w_idx = addr[BLOCK_OFFSET_WIDTH +: INDEX_WIDTH];
    assign w_off = addr[BLOCK_OFFSET_WIDTH-1:0];

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int j = 0; j < WAYS; j++) begin
            if (!w_hit && r_valid[f_ent(w_idx, WAY_W'(j))] &&
                r_tag[f_ent(w_idx, WAY_W'(j))] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(j);
            end
        end
    end

    // Lowest invalid way wins; with a full set the oldest (all-ones age) is evicted.
    always_comb begin
        w_inv     = 1'b0;
        w_vic_way = '0;
        for (int j = 0; j < WAYS; j++) begin
            if (!w_inv && !r_valid[f_ent(w_idx, WAY_W'(j))]) begin
                w_inv     = 1'b1;
                w_vic_way = WAY_W'(j);
            end
        end
        if (!w_inv) begin
            for (int j = 0; j < WAYS; j++) begin
                if (r_age[f_ent(w_idx, WAY_W'(j))] == c_AGE_MAX) w_vic_way = WAY_W'(j);
            end
        end
    end

    assign w_hit_ent  = f_ent(w_idx, w_hit_way);
    assign w_vic_ent  = f_ent(w_idx, w_vic_way);
    assign w_lat_ent  = f_ent(r_idx_l, r_way_l);
    assign w_served   = (r_state == S_READY) && !flush && enable && w_hit;
    assign w_fl_dirty = r_valid[r_scan] && r_dirty[r_scan];
    assign w_fl_idx   = r_scan[ENT_W-1:ASSO_WIDTH];

    assign w_touch     = w_served || ((r_state == S_REFILL) && mem_last);
    assign w_touch_idx = (r_state == S_READY) ? w_idx : r_idx_l;
    assign w_touch_way = (r_state == S_READY) ? w_hit_way : r_way_l;
    assign w_touch_old = r_age[f_ent(w_touch_idx, w_touch_way)];

    assign ready      = (r_state == S_READY);
    assign data_valid = w_served;
    assign data       = r_line[{w_hit_ent, w_off}];

    always_comb begin
        mem_enable = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (r_state)
            S_WRITEBACK: begin
                mem_enable = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {r_tag[w_lat_ent], r_idx_l, {BLOCK_OFFSET_WIDTH{1'b0}}};
                mem_wdata  = r_line[{w_lat_ent, r_cnt}];
            end
            S_REFILL: begin
                mem_enable = 1'b1;
                mem_addr   = {r_tag_l, r_idx_l, {BLOCK_OFFSET_WIDTH{1'b0}}};
            end
            S_FLUSH: begin
                mem_enable = w_fl_dirty;
                mem_write  = w_fl_dirty;
                mem_addr   = {r_tag[r_scan], w_fl_idx, {BLOCK_OFFSET_WIDTH{1'b0}}};
                mem_wdata  = r_line[{r_scan, r_cnt}];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_READY;
            r_cnt   <= '0;
            r_scan  <= '0;
            r_valid <= '0;
            r_dirty <= '0;
            for (int e = 0; e < ENTRIES; e++) r_age[e] <= WAY_W'(e % WAYS);
        end else begin
            if (w_touch) begin
                for (int j = 0; j < WAYS; j++) begin
                    if (WAY_W'(j) == w_touch_way)
                        r_age[f_ent(w_touch_idx, WAY_W'(j))] <= '0;
                    else if (r_age[f_ent(w_touch_idx, WAY_W'(j))] < w_touch_old)
                        r_age[f_ent(w_touch_idx, WAY_W'(j))] <=
                            r_age[f_ent(w_touch_idx, WAY_W'(j))] + 1'b1;
                end
            end
            case (r_state)
                S_READY: begin
                    if (flush) begin
                        r_state <= S_FLUSH;
                        r_scan  <= '0;
                        r_cnt   <= '0;
                    end else if (enable && w_hit) begin
                        if (write && (|wstrb)) r_dirty[w_hit_ent] <= 1'b1;
                    end else if (enable) begin
                        r_tag_l <= w_tag;
                        r_idx_l <= w_idx;
                        r_way_l <= w_vic_way;
                        r_cnt   <= '0;
                        r_state <= (r_valid[w_vic_ent] && r_dirty[w_vic_ent]) ? S_WRITEBACK : S_REFILL;
                    end
                end
                S_WRITEBACK: begin
                    if (mem_write_ready) r_cnt <= r_cnt + 1'b1;
                    if (mem_write_ready && mem_last) begin
                        r_dirty[w_lat_ent] <= 1'b0;
                        r_cnt              <= '0;
                        r_state            <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (mem_read_valid) r_cnt <= r_cnt + 1'b1;
                    if (mem_last) begin
                        r_tag[w_lat_ent]   <= r_tag_l;
                        r_valid[w_lat_ent] <= 1'b1;
                        r_dirty[w_lat_ent] <= 1'b0;
                        r_cnt              <= '0;
                        r_state            <= S_READY;
                    end
                end
                default: begin
                    // Clean entries retire in one cycle; dirty ones after their burst.
                    if (w_fl_dirty && mem_write_ready) r_cnt <= r_cnt + 1'b1;
                    if (!w_fl_dirty || (mem_write_ready && mem_last)) begin
                        r_valid[r_scan] <= 1'b0;
                        r_dirty[r_scan] <= 1'b0;
                        r_cnt           <= '0;
                        if (r_scan == c_LAST_ENT) r_state <= S_READY;
                        else                      r_scan  <= r_scan + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_served && write) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wstrb[b]) r_line[{w_hit_ent, w_off}][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            if (r_state == S_REFILL && mem_read_valid) r_line[{w_lat_ent, r_cnt}] <= mem_read;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_cache
// Purpose  : Randomized self-checking bench for data_cache against a flat
//            memory image plus a per-set LRU tag list.
// Revision : 1.0
// ============================================================================
module tb_data_cache;
    localparam int WAYS  = 2;
    localparam int WORDS = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic        enable;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        flush;
    logic        ready;
    logic [31:0] data;
    logic        data_valid;
    logic [15:0] mem_addr;
    logic        mem_enable;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_read;
    logic        mem_read_valid;
    logic        mem_write_ready;
    logic        mem_last;

    data_cache dut (
        .clk(clk), .rst(rst), .addr(addr), .enable(enable), .write(write),
        .wdata(wdata), .wstrb(wstrb), .flush(flush), .ready(ready), .data(data),
        .data_valid(data_valid), .mem_addr(mem_addr), .mem_enable(mem_enable),
        .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_read_valid(mem_read_valid), .mem_write_ready(mem_write_ready),
        .mem_last(mem_last)
    );

    always #5 clk = ~clk;

    logic [31:0] bmem    [65536];
    logic [31:0] ref_mem [65536];
    logic [7:0]  lru_q   [8][$];
    bit          mdirty  [256][8];
    logic [16:0] blog    [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          bcnt = 0;
    int          in_burst = 0;
    int          tick = 0;
    int          thr_div = 1;
    int          wbeats = 0;
    logic [15:0] beat;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Burst memory: beats are presented at the falling edge and taken at the next rising edge.
    always @(negedge clk) begin
        tick++;
        mem_read_valid  = 1'b0;
        mem_write_ready = 1'b0;
        mem_last        = 1'b0;
        if (rst || !mem_enable) begin
            in_burst = 0;
            bcnt     = 0;
        end else begin
            if (in_burst == 0) begin
                blog.push_back({mem_write, mem_addr});
                in_burst = 1;
                bcnt     = 0;
            end
            if (thr_div == 0 ? ($urandom_range(0, 1) == 0) : (tick % thr_div == 0)) begin
                beat     = {mem_addr[15:5], 5'(bcnt)};
                mem_last = (bcnt == WORDS - 1);
                if (mem_write) begin
                    mem_write_ready = 1'b1;
                    wbeats++;
                    check_eq("wb_beat", mem_wdata, ref_mem[beat]);
                    bmem[beat] = mem_wdata;
                end else begin
                    mem_read_valid = 1'b1;
                    mem_read       = bmem[beat];
                end
                if (mem_last) begin
                    in_burst = 0;
                    bcnt     = 0;
                end else begin
                    bcnt++;
                end
            end
        end
    end

    task automatic access(input logic [15:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd);
        logic [7:0]  t;
        logic [7:0]  v;
        logic [2:0]  si;
        logic [16:0] exp_log[$];
        int          pos;
        int          base;
        int          cyc;
        t   = a[15:8];
        si  = a[7:5];
        pos = -1;
        for (int k = 0; k < lru_q[si].size(); k++) if (lru_q[si][k] == t) pos = k;
        if (pos < 0) begin
            if (lru_q[si].size() == WAYS) begin
                v = lru_q[si][WAYS-1];
                if (mdirty[v][si]) exp_log.push_back({1'b1, v, si, 5'd0});
                mdirty[v][si] = 1'b0;
                lru_q[si].delete(WAYS-1);
            end
            exp_log.push_back({1'b0, t, si, 5'd0});
        end else begin
            lru_q[si].delete(pos);
        end
        lru_q[si].push_front(t);
        base = blog.size();
        @(negedge clk);
        addr = a; enable = 1'b1; write = w; wdata = d; wstrb = s;
        #1;
        cyc = 0;
        while (!data_valid && cyc < 5000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check_eq("done", data_valid, 1);
        check_eq("hit", (cyc == 0), (pos >= 0));
        if (pos < 0) check_eq("miss_lat", (cyc > WORDS), 1);
        rd = data;
        if (!w) begin
            check_eq("load", data, ref_mem[a]);
        end else begin
            for (int b = 0; b < 4; b++) if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
            if (s != 4'b0) mdirty[t][si] = 1'b1;
        end
        @(posedge clk);
        #1;
        enable = 1'b0;
        check_eq("nburst", blog.size() - base, exp_log.size());
        for (int k = 0; k < exp_log.size() && base + k < blog.size(); k++)
            check_eq("burst", {15'd0, blog[base+k]}, {15'd0, exp_log[k]});
    endtask

    task automatic do_flush(output int nwr);
        int ndirty;
        int base;
        int cyc;
        ndirty = 0;
        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < lru_q[s].size(); k++) begin
                if (mdirty[lru_q[s][k]][s]) ndirty++;
                mdirty[lru_q[s][k]][s] = 1'b0;
            end
            lru_q[s].delete();
        end
        base = blog.size();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        cyc = 0;
        while (!ready && cyc < 10000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check_eq("flush_ready", ready, 1);
        nwr = blog.size() - base;
        check_eq("flush_nwr", nwr, ndirty);
        for (int k = base; k < blog.size(); k++) check_eq("flush_wr", blog[k][16], 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [15:0] a;
        int          nwr;
        int          base;
        int          wb0;
        int          cyc;
        int          nbad;
        for (int i = 0; i < 65536; i++) begin
            bmem[i]    = $urandom;
            ref_mem[i] = bmem[i];
        end
        bmem[16'h0123]    = 32'h11223344;
        ref_mem[16'h0123] = 32'h11223344;
        rst = 1'b1; addr = '0; enable = 1'b0; write = 1'b0; wdata = '0; wstrb = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("rst_ready", ready, 1);
        check_eq("rst_dvalid", data_valid, 0);
        check_eq("rst_menable", mem_enable, 0);
        check_eq("rst_mwrite", mem_write, 0);

        access(16'h0123, 1'b0, '0, '0, rd);
        check_eq("t1_data", rd, 32'h11223344);
        access(16'h0123, 1'b0, '0, '0, rd);
        check_eq("t1_rehit", rd, 32'h11223344);

        access(16'h0123, 1'b1, 32'hDEADBEEF, 4'b0011, rd);
        access(16'h0123, 1'b0, '0, '0, rd);
        check_eq("t2_merge", rd, 32'h1122BEEF);

        access(16'h0223, 1'b1, 32'hCAFEF00D, 4'b1111, rd);
        access(16'h0123, 1'b0, '0, '0, rd);
        base = blog.size();
        access(16'h0323, 1'b0, '0, '0, rd);
        check_eq("t3_nburst", blog.size() - base, 2);
        if (blog.size() >= base + 2) begin
            check_eq("t3_wb", {15'd0, blog[base]}, 32'h0001_0220);
            check_eq("t3_rd", {15'd0, blog[base+1]}, 32'h0000_0320);
        end

        thr_div = 3;
        wb0 = wbeats;
        access(16'h0523, 1'b0, '0, '0, rd);
        check_eq("t4_beats", wbeats - wb0, WORDS);
        thr_div = 1;

        access(16'h0040, 1'b1, $urandom, 4'b1111, rd);
        access(16'h0060, 1'b1, $urandom, 4'b0101, rd);
        access(16'h0540, 1'b1, $urandom, 4'b1000, rd);
        do_flush(nwr);
        check_eq("t5_nwr", nwr, 3);
        access(16'h0040, 1'b0, '0, '0, rd);
        access(16'h0323, 1'b0, '0, '0, rd);

        do_flush(nwr);
        @(negedge clk);
        addr = 16'h0763; enable = 1'b1; write = 1'b0; wstrb = '0;
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
        end while (bcnt != 10 && cyc < 2000);
        check_eq("t6_reach", (bcnt == 10), 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t6_menable", mem_enable, 0);
        check_eq("t6_ready", ready, 1);
        check_eq("t6_dvalid", data_valid, 0);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 8; s++) lru_q[s].delete();
        access(16'h0763, 1'b0, '0, '0, rd);

        thr_div = 0;
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_flush(nwr);
            end else begin
                a = {8'($urandom_range(0, 5)), 3'($urandom_range(0, 7)), 5'($urandom)};
                access(a, 1'($urandom), $urandom, 4'($urandom), rd);
            end
        end
        do_flush(nwr);
        nbad = 0;
        for (int i = 0; i < 65536; i++) if (bmem[i] !== ref_mem[i]) nbad++;
        check_eq("mem_image", nbad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
